thread_pc_scheduler: RTL and testbench

//  Front of the fetch stage of the barrel core. Holds one PC per hardware thread and issues one fetch per cycle
//  in strict round-robin thread order to the instruction BRAM port. Consumes taken-branch/jump redirects from

---
 rtl/thread_pc_scheduler_pkg.sv | 20 ++
 rtl/thread_pc_scheduler_ram.sv | 44 ++++
 rtl/thread_pc_scheduler.sv | 108 ++++++++++
 tb/tb_thread_pc_scheduler.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/thread_pc_scheduler_pkg.sv
// Shared constants for the barrel-core fetch front end: data width, BRAM sizing,
// reset PC and the pipeline depth that bounds the minimum thread count.
package thread_pc_scheduler_pkg;

  localparam int DWIDTH          = 32;
  localparam int NUM_THREADS_DEF = 32;
  localparam int MEMORY_SIZE     = 2048;
  localparam int ADDR_WIDTH_DEF  = $clog2(MEMORY_SIZE);
  localparam int NUM_PIPE_STAGES = 3;
  localparam int TID_WIDTH       = $clog2(NUM_THREADS_DEF);

  localparam logic [DWIDTH-3:0] STARTUP_ADDR = '0;
  localparam logic [DWIDTH-1:0] START_PC_DEF = {STARTUP_ADDR, 2'b00};

  // Instruction fetch is word-granular, so the low two PC bits are always dropped.
  function automatic logic [DWIDTH-1:0] align_pc(input logic [DWIDTH-1:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/thread_pc_scheduler_ram.sv
// Per-thread PC storage: one async read, an increment write port and a redirect write port.
// Latency: read combinational, writes visible next cycle. No backpressure.
module thread_pc_ram
  import thread_pc_scheduler_pkg::*;
#(
  parameter int                NUM_THREADS = NUM_THREADS_DEF,
  parameter logic [DWIDTH-1:0] INIT_PC     = START_PC_DEF,
  localparam int               TID_W       = $clog2(NUM_THREADS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [TID_W-1:0]  rd_tid,
  output logic [DWIDTH-1:0] rd_pc,
  input  logic              inc_en,
  input  logic [TID_W-1:0]  inc_tid,
  input  logic [DWIDTH-1:0] inc_pc,
  input  logic              wr_en,
  input  logic [TID_W-1:0]  wr_tid,
  input  logic [DWIDTH-1:0] wr_pc
);

  logic [DWIDTH-1:0]      mem [NUM_THREADS];
  logic [NUM_THREADS-1:0] written;

  // The storage itself has no reset; an entry reads as INIT_PC until first written after reset.
  assign rd_pc = written[rd_tid] ? mem[rd_tid] : INIT_PC;

  always_ff @(posedge clk) begin
    if (inc_en) mem[inc_tid] <= inc_pc;
    if (wr_en)  mem[wr_tid]  <= wr_pc;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      written <= '0;
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        if ((inc_en && inc_tid == TID_W'(i)) || (wr_en && wr_tid == TID_W'(i)))
          written[i] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/thread_pc_scheduler.sv
// Round-robin per-thread PC issue into the instruction BRAM, with redirect and halt handling.
// Latency: 1 cycle from slot selection to fetch_* outputs. No backpressure; run_i=0 freezes issue.
module thread_pc_scheduler
  import thread_pc_scheduler_pkg::*;
#(
  parameter int                NUM_THREADS = NUM_THREADS_DEF,
  parameter int                ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter logic [DWIDTH-1:0] START_PC    = START_PC_DEF,
  localparam int               TID_W       = $clog2(NUM_THREADS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   run_i,
  input  logic                   redir_valid_i,
  input  logic [TID_W-1:0]       redir_tid_i,
  input  logic [DWIDTH-1:0]      redir_pc_i,
  input  logic                   halt_valid_i,
  input  logic [TID_W-1:0]       halt_tid_i,
  output logic                   fetch_valid_o,
  output logic [TID_W-1:0]       fetch_tid_o,
  output logic [DWIDTH-1:0]      fetch_pc_o,
  output logic [ADDR_WIDTH-1:0]  fetch_addr_o,
  output logic [NUM_THREADS-1:0] active_o,
  output logic                   misalign_o
);

  typedef struct packed {
    logic              valid;
    logic [TID_W-1:0]  tid;
    logic [DWIDTH-1:0] pc;
  } fetch_slot_t;

  localparam logic [TID_W-1:0] LAST_TID = TID_W'(NUM_THREADS - 1);
  localparam logic [TID_W:0]   TID_LIM  = (TID_W+1)'(NUM_THREADS);

  if (NUM_THREADS < 2 || NUM_THREADS < NUM_PIPE_STAGES) begin : g_bad_threads
    $error("thread_pc_scheduler: NUM_THREADS must be >= 2 and >= NUM_PIPE_STAGES");
  end

  fetch_slot_t            slot_q;
  logic [TID_W-1:0]       slot_tid;
  logic [NUM_THREADS-1:0] active;
  logic                   misalign;
  logic [DWIDTH-1:0]      issue_pc;
  logic                   redir_ok;
  logic                   halt_ok;
  logic                   inc_en;
  logic                   wr_en;

  // Out-of-range thread ids are dropped rather than aliased onto a real thread.
  assign redir_ok = redir_valid_i && ({1'b0, redir_tid_i} < TID_LIM);
  assign halt_ok  = halt_valid_i  && ({1'b0, halt_tid_i}  < TID_LIM);

  // A redirect to the issuing thread overrides its +4 update.
  assign inc_en = reset_n && run_i && active[slot_tid] &&
                  !(redir_ok && redir_tid_i == slot_tid);
  assign wr_en  = reset_n && redir_ok;

  thread_pc_ram #(
    .NUM_THREADS (NUM_THREADS),
    .INIT_PC     (START_PC)
  ) u_pc_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .rd_tid  (slot_tid),
    .rd_pc   (issue_pc),
    .inc_en  (inc_en),
    .inc_tid (slot_tid),
    .inc_pc  (issue_pc + 32'd4),
    .wr_en   (wr_en),
    .wr_tid  (redir_tid_i),
    .wr_pc   (align_pc(redir_pc_i))
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slot_tid <= '0;
      active   <= '1;
      misalign <= 1'b0;
      slot_q   <= '{valid: 1'b0, tid: '0, pc: START_PC};
    end else begin
      if (run_i) begin
        slot_q   <= '{valid: active[slot_tid], tid: slot_tid, pc: issue_pc};
        slot_tid <= (slot_tid == LAST_TID) ? '0 : slot_tid + TID_W'(1);
      end else begin
        slot_q.valid <= 1'b0;
      end
      // Halts take effect after the current slot has already been issued.
      for (int i = 0; i < NUM_THREADS; i++) begin
        if (halt_ok && halt_tid_i == TID_W'(i)) active[i] <= 1'b0;
      end
      if (redir_ok && redir_pc_i[1:0] != 2'b00) misalign <= 1'b1;
    end
  end

  assign fetch_valid_o = slot_q.valid;
  assign fetch_tid_o   = slot_q.tid;
  assign fetch_pc_o    = slot_q.pc;
  assign fetch_addr_o  = slot_q.pc[ADDR_WIDTH+1:2];
  assign active_o      = active;
  assign misalign_o    = misalign;

  a_redir_tid_range: assert property (@(posedge clk) disable iff (!reset_n)
    redir_valid_i |-> ({1'b0, redir_tid_i} < TID_LIM));
  a_halt_tid_range: assert property (@(posedge clk) disable iff (!reset_n)
    halt_valid_i |-> ({1'b0, halt_tid_i} < TID_LIM));

endmodule

// File: tb/tb_thread_pc_scheduler.sv
// Directed scoreboard bench: a 4-thread instance for issue/redirect/halt/freeze/misalign
// and a 3-thread instance for non-power-of-two wrap, PC overflow and mid-stream reset.
module tb_thread_pc_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          cyc;
    logic        v;
    logic [1:0]  t;
    logic [31:0] pc;
    logic [3:0]  act;
    logic        mis;
    string       name;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];

  // 4-thread instance
  logic        rst4, run4, rv4, hv4;
  logic [1:0]  rt4, ht4;
  logic [31:0] rp4;
  logic        fv4, mis4;
  logic [1:0]  ft4;
  logic [31:0] fp4;
  logic [10:0] fa4;
  logic [3:0]  act4;

  // 3-thread instance
  logic        rst3, run3, rv3, hv3;
  logic [1:0]  rt3, ht3;
  logic [31:0] rp3;
  logic        fv3, mis3;
  logic [1:0]  ft3;
  logic [31:0] fp3;
  logic [10:0] fa3;
  logic [2:0]  act3;

  thread_pc_scheduler #(.NUM_THREADS(4)) u_dut4 (
    .clk(clk), .reset_n(rst4), .run_i(run4),
    .redir_valid_i(rv4), .redir_tid_i(rt4), .redir_pc_i(rp4),
    .halt_valid_i(hv4), .halt_tid_i(ht4),
    .fetch_valid_o(fv4), .fetch_tid_o(ft4), .fetch_pc_o(fp4), .fetch_addr_o(fa4),
    .active_o(act4), .misalign_o(mis4)
  );

  thread_pc_scheduler #(.NUM_THREADS(3)) u_dut3 (
    .clk(clk), .reset_n(rst3), .run_i(run3),
    .redir_valid_i(rv3), .redir_tid_i(rt3), .redir_pc_i(rp3),
    .halt_valid_i(hv3), .halt_tid_i(ht3),
    .fetch_valid_o(fv3), .fetch_tid_o(ft3), .fetch_pc_o(fp3), .fetch_addr_o(fa3),
    .active_o(act3), .misalign_o(mis3)
  );

  task automatic chk(input string nm, input string fld, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s.%s got=%h want=%h (cycle %0d)", nm, fld, got, want, cyc);
    end
  endtask

  // Monitor: compares whichever expectations are due after the most recent rising edge.
  always @(negedge clk) begin
    exp_t e;
    while (q4.size() > 0 && q4[0].cyc <= cyc) begin
      e = q4.pop_front();
      chk(e.name, "when",  32'(cyc),  32'(e.cyc));
      chk(e.name, "valid", 32'(fv4),  32'(e.v));
      chk(e.name, "tid",   32'(ft4),  32'(e.t));
      chk(e.name, "pc",    fp4,       e.pc);
      chk(e.name, "addr",  32'(fa4),  32'(e.pc[12:2]));
      chk(e.name, "active",32'(act4), 32'(e.act));
      chk(e.name, "mis",   32'(mis4), 32'(e.mis));
    end
    while (q3.size() > 0 && q3[0].cyc <= cyc) begin
      e = q3.pop_front();
      chk(e.name, "when",  32'(cyc),  32'(e.cyc));
      chk(e.name, "valid", 32'(fv3),  32'(e.v));
      chk(e.name, "tid",   32'(ft3),  32'(e.t));
      chk(e.name, "pc",    fp3,       e.pc);
      chk(e.name, "addr",  32'(fa3),  32'(e.pc[12:2]));
      chk(e.name, "active",32'(act3), 32'(e.act));
      chk(e.name, "mis",   32'(mis3), 32'(e.mis));
    end
  end

  task automatic step4(input logic rst, input logic run, input logic rv, input logic [1:0] rt,
                       input logic [31:0] rp, input logic hv, input logic [1:0] ht,
                       input logic ev, input logic [1:0] et, input logic [31:0] epc,
                       input logic [3:0] eact, input logic emis, input string nm);
    exp_t e;
    rst4 = rst; run4 = run; rv4 = rv; rt4 = rt; rp4 = rp; hv4 = hv; ht4 = ht;
    e.cyc = cyc + 1; e.v = ev; e.t = et; e.pc = epc; e.act = eact; e.mis = emis; e.name = nm;
    q4.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic step3(input logic rst, input logic run, input logic rv, input logic [1:0] rt,
                       input logic [31:0] rp, input logic hv, input logic [1:0] ht,
                       input logic ev, input logic [1:0] et, input logic [31:0] epc,
                       input logic [2:0] eact, input logic emis, input string nm);
    exp_t e;
    rst3 = rst; run3 = run; rv3 = rv; rt3 = rt; rp3 = rp; hv3 = hv; ht3 = ht;
    e.cyc = cyc + 1; e.v = ev; e.t = et; e.pc = epc; e.act = {1'b0, eact}; e.mis = emis; e.name = nm;
    q3.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst4 = 1'b0; run4 = 1'b0; rv4 = 1'b0; rt4 = '0; rp4 = '0; hv4 = 1'b0; ht4 = '0;
    rst3 = 1'b0; run3 = 1'b0; rv3 = 1'b0; rt3 = '0; rp3 = '0; hv3 = 1'b0; ht3 = '0;
    @(posedge clk); #1;

    // ---- 4 threads ----  rst run rv rt rp hv ht | v t pc act mis
    step4(0,1,0,0,32'h0,0,0, 0,0,32'h0,4'hF,0,"rst_a");
    step4(0,1,0,0,32'h0,0,0, 0,0,32'h0,4'hF,0,"rst_b");
    step4(1,1,0,0,32'h0,0,0, 1,0,32'h0,4'hF,0,"t1_s0");
    step4(1,1,0,0,32'h0,0,0, 1,1,32'h0,4'hF,0,"t1_s1");
    step4(1,1,0,0,32'h0,0,0, 1,2,32'h0,4'hF,0,"t1_s2");
    step4(1,1,0,0,32'h0,0,0, 1,3,32'h0,4'hF,0,"t1_s3");
    step4(1,1,0,0,32'h0,0,0, 1,0,32'h4,4'hF,0,"t1_s4");
    step4(1,1,0,0,32'h0,0,0, 1,1,32'h4,4'hF,0,"t1_s5");
    step4(1,1,1,2,32'h100,0,0, 1,2,32'h4,4'hF,0,"t2_same_slot");
    step4(1,1,0,0,32'h0,0,0, 1,3,32'h4,4'hF,0,"t2_t3");
    step4(1,1,0,0,32'h0,0,0, 1,0,32'h8,4'hF,0,"t2_t0");
    step4(1,1,0,0,32'h0,0,0, 1,1,32'h8,4'hF,0,"t2_t1");
    step4(1,1,0,0,32'h0,0,0, 1,2,32'h100,4'hF,0,"t2_redir");
    step4(1,1,0,0,32'h0,1,1, 1,3,32'h8,4'hD,0,"t3_halt");
    step4(1,1,0,0,32'h0,0,0, 1,0,32'hC,4'hD,0,"t3_t0");
    step4(1,1,1,1,32'h200,0,0, 0,1,32'hC,4'hD,0,"t3_dead");
    step4(1,1,0,0,32'h0,0,0, 1,2,32'h104,4'hD,0,"t3_t2");
    step4(1,1,0,0,32'h0,0,0, 1,3,32'hC,4'hD,0,"t3_t3");
    step4(1,1,0,0,32'h0,0,0, 1,0,32'h10,4'hD,0,"t3_t0b");
    step4(1,1,0,0,32'h0,0,0, 0,1,32'h200,4'hD,0,"t3_dead_redir");
    step4(1,0,0,0,32'h0,0,0, 0,1,32'h200,4'hD,0,"t4_frz0");
    step4(1,0,0,0,32'h0,0,0, 0,1,32'h200,4'hD,0,"t4_frz1");
    step4(1,0,0,0,32'h0,0,0, 0,1,32'h200,4'hD,0,"t4_frz2");
    step4(1,1,0,0,32'h0,0,0, 1,2,32'h108,4'hD,0,"t4_resume");
    step4(1,1,0,0,32'h0,0,0, 1,3,32'h10,4'hD,0,"t4_t3");
    step4(1,1,1,0,32'h102,0,0, 1,0,32'h14,4'hD,1,"t5_mis");
    step4(1,1,0,0,32'h0,0,0, 0,1,32'h200,4'hD,1,"t5_t1");
    step4(1,1,1,3,32'h300,0,0, 1,2,32'h10C,4'hD,1,"redir_other");
    step4(1,1,0,0,32'h0,0,0, 1,3,32'h300,4'hD,1,"redir_other_t3");
    step4(1,1,0,0,32'h0,0,0, 1,0,32'h100,4'hD,1,"t5_addr");
    step4(1,1,0,0,32'h0,0,0, 0,1,32'h200,4'hD,1,"t5_t1b");
    step4(1,1,0,0,32'h0,0,0, 1,2,32'h110,4'hD,1,"inc_other");
    run4 = 1'b0;

    // ---- 3 threads ----  rst run rv rt rp hv ht | v t pc act mis
    step3(0,1,0,0,32'h0,0,0, 0,0,32'h0,3'h7,0,"r3_rst");
    step3(1,1,0,0,32'h0,0,0, 1,0,32'h0,3'h7,0,"r3_s0");
    step3(1,1,0,0,32'h0,0,0, 1,1,32'h0,3'h7,0,"r3_s1");
    step3(1,1,1,1,32'hFFFF_FFFC,0,0, 1,2,32'h0,3'h7,0,"r3_s2");
    step3(1,1,0,0,32'h0,0,0, 1,0,32'h4,3'h7,0,"t6_wrap");
    step3(1,1,0,0,32'h0,0,0, 1,1,32'hFFFF_FFFC,3'h7,0,"t6_pcmax");
    step3(1,1,0,0,32'h0,0,0, 1,2,32'h4,3'h7,0,"r3_t2");
    step3(1,1,0,0,32'h0,1,0, 1,0,32'h8,3'h6,0,"halt_own_slot");
    step3(1,1,1,2,32'h3,0,0, 1,1,32'h0,3'h6,1,"t6_pc_overflow");
    step3(0,1,0,0,32'h0,0,0, 0,0,32'h0,3'h7,0,"t6_mid_rst");
    step3(1,1,0,0,32'h0,0,0, 1,0,32'h0,3'h7,0,"t6_post_s0");
    step3(1,1,0,0,32'h0,0,0, 1,1,32'h0,3'h7,0,"t6_post_s1");
    step3(1,1,0,0,32'h0,0,0, 1,2,32'h0,3'h7,0,"t6_post_s2");
    run3 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("drain", "q4_left", 32'(q4.size()), 32'd0);
    chk("drain", "q3_left", 32'(q3.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
